// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - CPU run-control bundle between the run/step controller and the core
//
// Purpose: carries the clock-enable, stall, mode and retired-step count from
//          cpu_run_ctrl to the pipelined CPU core and the display path.
// Signals:
//   cpu_ce     - one-cycle CPU clock-enable pulse per CPU advance
//   cpu_stall  - high whenever the controller is not in free-run
//   mode       - 00 HALT, 01 RUN, 10 STEP
//   step_count - cpu_ce pulses issued since reset, wraps at 16 bits
// Modports:
//   master - the run controller (drives everything)
//   slave  - the CPU core / display (observes everything)

interface cpu_run_ctrl_if;
    logic        cpu_ce;
    logic        cpu_stall;
    logic [1:0]  mode;
    logic [15:0] step_count;

    modport master (
        output cpu_ce,
        output cpu_stall,
        output mode,
        output step_count
    );

    modport slave (
        input cpu_ce,
        input cpu_stall,
        input mode,
        input step_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - HALT/RUN/STEP controller producing the CPU clock enable
//
// Purpose: synchronises and debounces the raw step button and run switch,
//          sequences HALT/RUN/STEP, and generates the CPU clock enable,
//          stall level and a retired-step counter.
// Parameters:
//   DEBOUNCE_CYCLES - consecutive stable edges before a raw change is accepted
//   RUN_DIV         - clock cycles per cpu_ce pulse while free-running (1..2^32-1)
// Ports:
//   clk      - 100 MHz board clock, all state on the rising edge
//   reset    - synchronous, active-high
//   btn_step - raw bouncing step push-button, active high
//   sw_run   - raw run switch, 1 = free-run
//   ctl      - cpu_run_ctrl_if.master: cpu_ce, cpu_stall, mode, step_count

module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RUN_DIV         = 50000000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_step,
    input  logic            sw_run,
    cpu_run_ctrl_if.master  ctl
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]     DIV_LAST = 32'(RUN_DIV - 1);

    // Input index: bit 0 = step button, bit 1 = run switch.
    localparam int BTN = 0;
    localparam int RUN = 1;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      db;
    logic [DB_W-1:0] db_cnt [2];
    logic            btn_db_prev;
    logic            step_req;

    state_t          state;
    logic [31:0]     div_cnt;
    logic [15:0]     step_cnt;
    logic            cpu_ce;

    assign raw = {sw_run, btn_step};

    // Two-flop synchronisers feed per-input debouncers. The debouncer only
    // looks at sync2; a change is accepted on the edge where sync2 has
    // disagreed with db for DEBOUNCE_CYCLES consecutive edges, and any
    // agreement in between restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1       <= '0;
            sync2       <= '0;
            db          <= '0;
            btn_db_prev <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1       <= raw;
            sync2       <= sync1;
            btn_db_prev <= db[BTN];
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced button only: one request per press,
    // nothing on release, nothing while held.
    assign step_req = db[BTN] & ~btn_db_prev;

    // HALT/RUN/STEP sequencer with the run-rate divider. The divider is held
    // at zero outside RUN, so entering RUN always starts a fresh period and
    // leaving RUN discards any partial period.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_HALT;
            div_cnt  <= '0;
            step_cnt <= '0;
        end else begin
            if (cpu_ce) begin
                step_cnt <= step_cnt + 16'd1;
            end

            case (state)
                ST_HALT: begin
                    div_cnt <= '0;
                    // Run switch wins over a simultaneous step request.
                    if (db[RUN]) begin
                        state <= ST_RUN;
                    end else if (step_req) begin
                        state <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    div_cnt <= '0;
                    state   <= ST_HALT;
                end
                ST_RUN: begin
                    if (!db[RUN]) begin
                        state   <= ST_HALT;
                        div_cnt <= '0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 32'd1;
                    end
                end
                default: begin
                    state   <= ST_HALT;
                    div_cnt <= '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only; no raw input reaches them
    // combinationally.
    assign cpu_ce = (state == ST_STEP) ||
                    ((state == ST_RUN) && (div_cnt == DIV_LAST));

    assign ctl.cpu_ce     = cpu_ce;
    assign ctl.cpu_stall  = (state != ST_RUN);
    assign ctl.mode       = state;
    assign ctl.step_count = step_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - directed scoreboard bench for cpu_run_ctrl

module tb_cpu_run_ctrl;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic btn_step  = 1'b1;
    logic sw_run    = 1'b1;
    logic btn_step2 = 1'b0;
    logic sw_run2   = 1'b0;

    always #5 clk = ~clk;

    cpu_run_ctrl_if ifa();
    cpu_run_ctrl_if ifb();

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_step (btn_step),
        .sw_run   (sw_run),
        .ctl      (ifa.master)
    );

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1)) dut_fast (
        .clk      (clk),
        .reset    (reset),
        .btn_step (btn_step2),
        .sw_run   (sw_run2),
        .ctl      (ifb.master)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int base   = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 ns after the edge and reconcile cpu_ce against
    // the expected-pulse queue.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ifa.cpu_ce === 1'b1) begin
            if (exp_q.size() == 0)
                chk("unexpected_ce", {63'd0, ifa.cpu_ce}, 64'd0);
            else
                chk("ce_cycle", cyc, exp_q.pop_front());
        end else if (exp_q.size() > 0 && exp_q[0] == cyc) begin
            chk("ce_missing", {63'd0, ifa.cpu_ce}, 64'd1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // Reset held two cycles with both inputs asserted.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_mode",  ifa.mode, 2'b00);
            chk("rst_ce",    ifa.cpu_ce, 1'b0);
            chk("rst_stall", ifa.cpu_stall, 1'b1);
            chk("rst_count", ifa.step_count, 16'd0);
        end
        reset    = 1'b0;
        btn_step = 1'b0;
        sw_run   = 1'b0;
        ticks(8);

        // Clean press held 20 cycles: one pulse after edge 7.
        base = cyc;
        btn_step = 1'b1;
        exp_q.push_back(base + 7);
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("step_mode", ifa.mode, (i == 7) ? 2'b10 : 2'b00);
        end
        btn_step = 1'b0;
        ticks(10);
        chk("step_drain", exp_q.size(), 0);
        chk("step_count1", ifa.step_count, 16'd1);

        // Bounce: 1,0,1,0 for 3 cycles each never qualifies.
        for (int j = 0; j < 4; j++) begin
            btn_step = (j % 2 == 0);
            ticks(3);
        end
        chk("bounce_count", ifa.step_count, 16'd1);
        base = cyc;
        btn_step = 1'b1;
        exp_q.push_back(base + 7);
        ticks(20);
        btn_step = 1'b0;
        ticks(10);
        chk("bounce_drain", exp_q.size(), 0);
        chk("bounce_count2", ifa.step_count, 16'd2);

        // Fresh reset so the free-run count starts at zero.
        reset = 1'b1;
        tick();
        chk("rst2_count", ifa.step_count, 16'd0);
        reset = 1'b0;
        ticks(2);

        // Free-run, with a step press in the middle and run dropped at 46.
        base = cyc;
        sw_run = 1'b1;
        for (int k = 0; k <= 14; k++) exp_q.push_back(base + 9 + 3 * k);
        for (int i = 1; i <= 70; i++) begin
            tick();
            chk("run_mode", ifa.mode, (i >= 7 && i < 52) ? 2'b01 : 2'b00);
            if (i == 7) chk("run_stall", ifa.cpu_stall, 1'b0);
            if (i == 37) chk("run_count10", ifa.step_count, 16'd10);
            if (i == 19) btn_step = 1'b1;
            if (i == 30) btn_step = 1'b0;
            if (i == 45) sw_run = 1'b0;
        end
        chk("run_drain", exp_q.size(), 0);
        chk("run_count_end", ifa.step_count, 16'd15);
        chk("run_stall_end", ifa.cpu_stall, 1'b1);

        // Reset two edges into a debounce count discards the press.
        btn_step = 1'b1;
        ticks(4);
        reset = 1'b1;
        btn_step = 1'b0;
        tick();
        chk("mid_rst_ce", ifa.cpu_ce, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_ce", ifa.cpu_ce, 1'b0);
        ticks(20);
        chk("mid_rst_count", ifa.step_count, 16'd0);
        base = cyc;
        btn_step = 1'b1;
        exp_q.push_back(base + 7);
        ticks(15);
        btn_step = 1'b0;
        ticks(10);
        chk("fresh_drain", exp_q.size(), 0);
        chk("fresh_count", ifa.step_count, 16'd1);

        // Wrap: RUN_DIV=1 pulses every RUN cycle; 65536 pulses wrap to zero.
        base = cyc;
        sw_run2 = 1'b1;
        for (int i = 1; i <= 7 + 65536; i++) begin
            tick();
            if (i == 7) chk("fast_mode", ifb.mode, 2'b01);
            if (i == 8) chk("fast_ce", ifb.cpu_ce, 1'b1);
            if (i == 7 + 65535) chk("wrap_ffff", ifb.step_count, 16'hFFFF);
        end
        chk("wrap_zero", ifb.step_count, 16'h0000);
        sw_run2 = 1'b0;
        ticks(10);
        chk("fast_halt", ifb.mode, 2'b00);
        chk("fast_halt_ce", ifb.cpu_ce, 1'b0);
        chk("final_drain", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
